// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline-register chain carrying ctrl/data with per-stage valid,
// stall/flush handling and saturating stall/bubble performance counters.
module pipe_stage_chain #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       cnt_clr_i,
  input  logic                       valid_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       valid_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           bubble_cnt_o
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be >= 1");
  end

  logic              valid_reg  [DEPTH];
  logic [CTRL_W-1:0] ctrl_reg   [DEPTH];
  logic [DATA_W-1:0] data_reg   [DEPTH];
  logic              valid_next [DEPTH];
  logic [CTRL_W-1:0] ctrl_next  [DEPTH];
  logic [DATA_W-1:0] data_next  [DEPTH];

  logic              src_valid [DEPTH];
  logic [CTRL_W-1:0] src_ctrl  [DEPTH];
  logic [DATA_W-1:0] src_data  [DEPTH];

  logic advance;
  assign advance = !flush_i && !stall_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // Gating ctrl at entry keeps every invalid stage's ctrl at zero.
        assign src_valid[gi] = valid_i;
        assign src_ctrl[gi]  = valid_i ? ctrl_i : '0;
        assign src_data[gi]  = data_i;
      end else begin : g_body
        assign src_valid[gi] = valid_reg[gi-1];
        assign src_ctrl[gi]  = ctrl_reg[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
      end

      always_comb begin
        valid_next[gi] = valid_reg[gi];
        ctrl_next[gi]  = ctrl_reg[gi];
        data_next[gi]  = data_reg[gi];
        if (flush_i) begin
          valid_next[gi] = 1'b0;
          ctrl_next[gi]  = '0;
        end else if (!stall_i) begin
          valid_next[gi] = src_valid[gi];
          ctrl_next[gi]  = src_ctrl[gi];
          data_next[gi]  = src_data[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (rst_i) begin
        valid_reg[k] <= 1'b0;
        ctrl_reg[k]  <= '0;
        data_reg[k]  <= '0;
      end else begin
        valid_reg[k] <= valid_next[k];
        ctrl_reg[k]  <= ctrl_next[k];
        data_reg[k]  <= data_next[k];
      end
    end
  end

  assign valid_o = valid_reg[DEPTH-1];
  assign ctrl_o  = ctrl_reg[DEPTH-1];
  assign data_o  = data_reg[DEPTH-1];

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy_o = occupancy_o + OCC_W'(valid_reg[k]);
    end
  end

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  // Stall cycles are counted even when a flush overrides the hold.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (stall_i && stall_cnt_reg != CNT_MAX) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (advance && !valid_reg[DEPTH-1] && bubble_cnt_reg != CNT_MAX) begin
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_reg;
  assign bubble_cnt_o = bubble_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=3, CNT_W=4): fill, stall, flush,
// bubble propagation, counter saturation/clear and mid-stream reset.
module tb_pipe_stage_chain;

  localparam int CTRL_W = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              cnt_clr = 1'b0;
  logic              valid_in = 1'b0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .cnt_clr_i(cnt_clr), .valid_i(valid_in), .ctrl_i(ctrl_in), .data_i(data_in),
    .valid_o(valid_out), .ctrl_o(ctrl_out), .data_o(data_out),
    .occupancy_o(occupancy), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    $display("[TB] edge %0d rst=%0b stall=%0b flush=%0b vin=%0b din=%0d -> vout=%0b ctrl=%0b dout=%0d occ=%0d scnt=%0d bcnt=%0d",
             edge_no, rst, stall, flush, valid_in, data_in, valid_out, ctrl_out,
             data_out, occupancy, stall_cnt, bubble_cnt);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] c,
                           input logic [7:0] d, input logic [1:0] occ);
    check({tag, "_valid"}, 32'(valid_out), 32'(v));
    check({tag, "_ctrl"},  32'(ctrl_out),  32'(c));
    check({tag, "_data"},  32'(data_out),  32'(d));
    check({tag, "_occ"},   32'(occupancy), 32'(occ));
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] s, input logic [3:0] b);
    check({tag, "_stall_cnt"},  32'(stall_cnt),  32'(s));
    check({tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'(b));
  endtask

  initial begin
    // Reset
    rst = 1'b1; valid_in = 1'b1; ctrl_in = 2'b11; data_in = 8'hAA;
    step(); step();
    check_out("reset", 1'b0, 2'b00, 8'd0, 2'd0);
    check_cnt("reset", 4'd0, 4'd0);

    // 1. Fill: data 1,2,3 -> data 1 emerges on the third edge
    rst = 1'b0; valid_in = 1'b1; ctrl_in = 2'b01;
    data_in = 8'd1; step();
    check_out("fill1", 1'b0, 2'b00, 8'd0, 2'd1);
    data_in = 8'd2; step();
    check_out("fill2", 1'b0, 2'b00, 8'd0, 2'd2);
    data_in = 8'd3; step();
    check_out("fill3", 1'b1, 2'b01, 8'd1, 2'd3);
    check_cnt("fill3", 4'd0, 4'd3);
    data_in = 8'd4; step();
    check_out("fill4", 1'b1, 2'b01, 8'd2, 2'd3);
    check_cnt("fill4", 4'd0, 4'd3);

    // 2. Stall four cycles: outputs frozen, no loss/duplication afterwards
    stall = 1'b1; data_in = 8'd5;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("stall", 1'b1, 2'b01, 8'd2, 2'd3);
    end
    check_cnt("stall", 4'd4, 4'd3);
    stall = 1'b0;
    data_in = 8'd5; step(); check_out("rel1", 1'b1, 2'b01, 8'd3, 2'd3);
    data_in = 8'd6; step(); check_out("rel2", 1'b1, 2'b01, 8'd4, 2'd3);
    data_in = 8'd7; step(); check_out("rel3", 1'b1, 2'b01, 8'd5, 2'd3);

    // 3. Flush with stall: all invalid, ctrl cleared, data held, stall counted
    stall = 1'b1; flush = 1'b1; data_in = 8'd8;
    step();
    check_out("flush", 1'b0, 2'b00, 8'd5, 2'd0);
    check_cnt("flush", 4'd5, 4'd3);

    // 4. Bubble with ctrl_i=11 reaches output with ctrl 00
    stall = 1'b0; flush = 1'b0;
    valid_in = 1'b0; ctrl_in = 2'b11; data_in = 8'd9; step();
    check_cnt("bub_in", 4'd5, 4'd4);
    valid_in = 1'b1; ctrl_in = 2'b10; data_in = 8'd10; step();
    data_in = 8'd11; step();
    check_out("bub_out", 1'b0, 2'b00, 8'd9, 2'd2);
    check_cnt("bub_out", 4'd5, 4'd6);
    data_in = 8'd12; step();
    check_out("after_bub", 1'b1, 2'b10, 8'd10, 2'd3);
    check_cnt("after_bub", 4'd5, 4'd7);

    // 5. Stall counter saturation at 15, then clear wins over increment
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_cnt("sat", 4'd15, 4'd7);
    check_out("sat", 1'b1, 2'b10, 8'd10, 2'd3);
    cnt_clr = 1'b1; step();
    check_cnt("clr", 4'd0, 4'd0);
    cnt_clr = 1'b0; step();
    check_cnt("post_clr", 4'd1, 4'd0);

    // 6. Reset mid-stream with stall, then refill
    rst = 1'b1; step();
    check_out("midrst", 1'b0, 2'b00, 8'd0, 2'd0);
    check_cnt("midrst", 4'd0, 4'd0);
    rst = 1'b0; stall = 1'b0; valid_in = 1'b1; ctrl_in = 2'b01;
    data_in = 8'd20; step();
    data_in = 8'd21; step();
    check_out("refill2", 1'b0, 2'b00, 8'd0, 2'd2);
    data_in = 8'd22; step();
    check_out("refill3", 1'b1, 2'b01, 8'd20, 2'd3);
    check_cnt("refill3", 4'd0, 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
